// File: rtl/down_counter_timer_pkg.sv
// Shared types and default sizes for the prescaled down-counter/timer.
package down_counter_timer_pkg;

  localparam int DEF_WIDTH      = 8;
  localparam int DEF_PRESCALE_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    RUN    = 2'd2,
    PAUSED = 2'd3
  } state_t;

endpackage

// File: rtl/down_counter_timer_if.sv
// Controller-facing bundle of the timer: reload handshake, run controls and status.
interface down_counter_timer_if
  import down_counter_timer_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int PRESCALE_W = DEF_PRESCALE_W
);

  logic                  load_valid;
  logic                  load_ready;
  logic [WIDTH-1:0]      load_value;
  logic [PRESCALE_W-1:0] prescale;
  logic                  start;
  logic                  pause;
  logic                  abort;
  logic                  auto_reload;
  logic [WIDTH-1:0]      count;
  logic                  busy;
  logic                  done;

  modport master (
    output load_valid, load_value, prescale, start, pause, abort, auto_reload,
    input  load_ready, count, busy, done
  );

  modport slave (
    input  load_valid, load_value, prescale, start, pause, abort, auto_reload,
    output load_ready, count, busy, done
  );

endinterface

// File: rtl/down_counter_timer_tick_prescaler.sv
// Prescale divider: while enabled, asserts tick once every prescale+1 cycles;
// the phase is frozen while disabled and cleared on clr.
module down_counter_timer_tick_prescaler
  import down_counter_timer_pkg::*;
#(
  parameter int PRESCALE_W = DEF_PRESCALE_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  clr,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] cnt_r;

  assign tick = en && (cnt_r == prescale);

  // Phase counter: clear beats tick beats increment; holds when disabled
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_r <= {PRESCALE_W{1'b0}};
    end else if (clr) begin
      cnt_r <= {PRESCALE_W{1'b0}};
    end else if (tick) begin
      cnt_r <= {PRESCALE_W{1'b0}};
    end else if (en) begin
      cnt_r <= cnt_r + {{(PRESCALE_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/down_counter_timer.sv
// Loadable, prescaled down-counter/timer: reload via valid/ready, count down to
// terminal, pulse done for one cycle, then stop or auto-reload.
module down_counter_timer
  import down_counter_timer_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int PRESCALE_W = DEF_PRESCALE_W
) (
  input logic                 clk,
  input logic                 rst,
  down_counter_timer_if.slave bus
);

  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_r;
  logic [WIDTH-1:0] count_r;
  logic [WIDTH-1:0] reload_r;
  logic             busy_r;
  logic             done_r;
  logic             load_ready_r;

  logic abort_hit_s;
  logic load_hit_s;
  logic pre_en_s;
  logic pre_clr_s;
  logic tick_s;

  // Abort in IDLE is a no-op, so it must not shadow a load offered there.
  assign abort_hit_s = bus.abort && (state_r != IDLE);
  assign load_hit_s  = bus.load_valid && load_ready_r;
  assign pre_en_s    = (state_r == RUN) && !bus.pause;
  assign pre_clr_s   = abort_hit_s || load_hit_s;

  down_counter_timer_tick_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .en       (pre_en_s),
    .clr      (pre_clr_s),
    .prescale (bus.prescale),
    .tick     (tick_s)
  );

  // Control FSM, down-counter and registered status outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r      <= IDLE;
      count_r      <= CNT_ZERO;
      reload_r     <= CNT_ZERO;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      load_ready_r <= 1'b1;
    end else begin
      done_r <= 1'b0;
      if (abort_hit_s) begin
        state_r      <= IDLE;
        count_r      <= CNT_ZERO;
        busy_r       <= 1'b0;
        load_ready_r <= 1'b1;
      end else if (load_hit_s) begin
        state_r      <= ARMED;
        count_r      <= bus.load_value;
        reload_r     <= bus.load_value;
        busy_r       <= 1'b0;
        load_ready_r <= 1'b1;
      end else begin
        case (state_r)
          IDLE: begin
            state_r <= IDLE;
          end
          ARMED: begin
            if (bus.start && (count_r != CNT_ZERO)) begin
              state_r      <= RUN;
              busy_r       <= 1'b1;
              load_ready_r <= 1'b0;
            end
          end
          RUN: begin
            if (bus.pause) begin
              state_r <= PAUSED;
            end else if (tick_s) begin
              if (count_r == CNT_ONE) begin
                done_r <= 1'b1;
                if (bus.auto_reload) begin
                  count_r <= reload_r;
                end else begin
                  count_r      <= CNT_ZERO;
                  state_r      <= IDLE;
                  busy_r       <= 1'b0;
                  load_ready_r <= 1'b1;
                end
              end else if (count_r != CNT_ZERO) begin
                count_r <= count_r - CNT_ONE;
              end
            end
          end
          PAUSED: begin
            if (!bus.pause) begin
              state_r <= RUN;
            end
          end
          default: begin
            state_r      <= IDLE;
            count_r      <= CNT_ZERO;
            busy_r       <= 1'b0;
            load_ready_r <= 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.count      = count_r;
  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.load_ready = load_ready_r;

endmodule

// File: tb/tb_down_counter_timer.sv
// Bench for down_counter_timer: directed scenarios plus randomized traffic, all
// checked against an elapsed-active-cycles model of the timer.
module tb_down_counter_timer;

  localparam int W  = 8;
  localparam int PW = 4;
  localparam int M_IDLE = 0, M_ARMED = 1, M_RUN = 2, M_PAUSED = 3;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  // Model: timer mode, reload value, active run cycles since start, divider
  int   m_st, m_r, m_n, m_p;
  logic m_done;

  down_counter_timer_if #(.WIDTH(W), .PRESCALE_W(PW)) bus ();

  down_counter_timer #(.WIDTH(W), .PRESCALE_W(PW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // The count is a pure function of reload and ticks elapsed while running.
  function automatic int exp_count();
    if (m_st == M_ARMED) return m_r;
    if (m_st == M_RUN || m_st == M_PAUSED) return m_r - ((m_n / (m_p + 1)) % m_r);
    return 0;
  endfunction

  task automatic model_step();
    int ticks;
    if (!rst) begin
      m_st = M_IDLE; m_r = 0; m_n = 0; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (bus.abort && m_st != M_IDLE) begin
        m_st = M_IDLE;
      end else if (bus.load_valid && (m_st == M_IDLE || m_st == M_ARMED)) begin
        m_r  = int'(bus.load_value);
        m_st = M_ARMED;
      end else if (m_st == M_ARMED) begin
        if (bus.start && m_r != 0) begin
          m_st = M_RUN; m_n = 0; m_p = int'(bus.prescale);
        end
      end else if (m_st == M_RUN) begin
        if (bus.pause) begin
          m_st = M_PAUSED;
        end else begin
          m_n++;
          ticks = m_n / (m_p + 1);
          if ((m_n % (m_p + 1)) == 0 && (ticks % m_r) == 0) begin
            m_done = 1'b1;
            if (!bus.auto_reload) m_st = M_IDLE;
          end
        end
      end else if (m_st == M_PAUSED) begin
        if (!bus.pause) m_st = M_RUN;
      end
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check_eq("m_count", 32'(bus.count), exp_count());
    check_eq("m_busy",  32'(bus.busy),  32'(m_st == M_RUN || m_st == M_PAUSED));
    check_eq("m_done",  32'(bus.done),  32'(m_done));
    check_eq("m_ready", 32'(bus.load_ready), 32'(m_st == M_IDLE || m_st == M_ARMED));
  endtask

  task automatic clear_ctl();
    bus.load_valid = 1'b0; bus.start = 1'b0; bus.pause = 1'b0; bus.abort = 1'b0;
  endtask

  task automatic to_idle();
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
  endtask

  task automatic load_and_start(input logic [W-1:0] v, input logic [PW-1:0] p, input logic ar);
    bus.prescale = p; bus.auto_reload = ar;
    bus.load_value = v; bus.load_valid = 1'b1;
    step();
    bus.load_valid = 1'b0; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    clear_ctl();
    bus.load_value = 8'd0; bus.prescale = 4'd0; bus.auto_reload = 1'b0;

    for (int i = 0; i < 3; i++) begin
      bus.load_valid = 1'($urandom_range(0, 1)); bus.start = 1'($urandom_range(0, 1));
      bus.abort = 1'($urandom_range(0, 1));      bus.pause = 1'($urandom_range(0, 1));
      bus.load_value = 8'($urandom_range(0, 255)); bus.prescale = 4'($urandom_range(0, 15));
      step();
      check_eq("rst_count", 32'(bus.count), 32'd0);
      check_eq("rst_busy",  32'(bus.busy),  32'd0);
      check_eq("rst_done",  32'(bus.done),  32'd0);
      check_eq("rst_ready", 32'(bus.load_ready), 32'd1);
    end
    clear_ctl();
    rst = 1'b1;
    step();

    // one-shot, prescale 0
    load_and_start(8'd5, 4'd0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      check_eq("os_count", 32'(bus.count), 32'(5 - i));
      check_eq("os_done",  32'(bus.done),  32'(i == 5));
      check_eq("os_busy",  32'(bus.busy),  32'(i != 5));
      step();
    end

    // auto-reload with prescale 2
    load_and_start(8'd3, 4'd2, 1'b1);
    for (int c = 0; c < 27; c++) begin
      check_eq("ar_count", 32'(bus.count), 32'(3 - ((c / 3) % 3)));
      check_eq("ar_done",  32'(bus.done),  32'(c > 0 && (c % 9) == 0));
      step();
    end
    to_idle();

    // pause and resume
    load_and_start(8'd10, 4'd0, 1'b0);
    for (int i = 0; i < 20 && bus.count != 8'd7; i++) step();
    check_eq("pz_reach7", 32'(bus.count), 32'd7);
    bus.pause = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("pz_hold", 32'(bus.count), 32'd7);
      check_eq("pz_busy", 32'(bus.busy),  32'd1);
      check_eq("pz_done", 32'(bus.done),  32'd0);
    end
    bus.pause = 1'b0;
    step();
    check_eq("pz_release", 32'(bus.count), 32'd7);
    for (int v = 6; v >= 0; v--) begin
      step();
      check_eq("pz_count", 32'(bus.count), 32'(v));
      check_eq("pz_done_end", 32'(bus.done), 32'(v == 0));
    end

    // abort at count 2
    load_and_start(8'd4, 4'd0, 1'b0);
    for (int i = 0; i < 20 && bus.count != 8'd2; i++) step();
    check_eq("ab_reach2", 32'(bus.count), 32'd2);
    to_idle();
    check_eq("ab_count", 32'(bus.count), 32'd0);
    check_eq("ab_busy",  32'(bus.busy),  32'd0);
    check_eq("ab_done",  32'(bus.done),  32'd0);
    check_eq("ab_ready", 32'(bus.load_ready), 32'd1);

    // zero load never runs
    bus.load_value = 8'd0; bus.load_valid = 1'b1;
    step();
    bus.load_valid = 1'b0; bus.start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("z_busy",  32'(bus.busy), 32'd0);
      check_eq("z_done",  32'(bus.done), 32'd0);
      check_eq("z_ready", 32'(bus.load_ready), 32'd1);
    end
    bus.start = 1'b0;
    to_idle();

    // load offered while running is refused
    load_and_start(8'd6, 4'd0, 1'b0);
    check_eq("lr_ready", 32'(bus.load_ready), 32'd0);
    bus.load_value = 8'd200; bus.load_valid = 1'b1;
    step();
    check_eq("lr_count", 32'(bus.count), 32'd5);
    bus.load_valid = 1'b0;
    to_idle();

    // load and start together in IDLE: load wins
    bus.load_value = 8'd9; bus.load_valid = 1'b1; bus.start = 1'b1;
    step();
    check_eq("ls_count", 32'(bus.count), 32'd9);
    check_eq("ls_busy",  32'(bus.busy),  32'd0);
    clear_ctl();
    step();
    check_eq("ls_armed", 32'(bus.busy), 32'd0);
    to_idle();

    // reset mid-run clears everything including done
    load_and_start(8'd2, 4'd0, 1'b0);
    step();
    rst = 1'b0;
    step();
    check_eq("mr_count", 32'(bus.count), 32'd0);
    check_eq("mr_done",  32'(bus.done),  32'd0);
    rst = 1'b1;
    step();

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      rst             = ($urandom_range(0, 199) != 0);
      bus.abort       = ($urandom_range(0, 39) == 0);
      bus.load_valid  = ($urandom_range(0, 5) == 0);
      bus.load_value  = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 6)) : 8'($urandom_range(0, 255));
      bus.start       = ($urandom_range(0, 2) == 0);
      bus.pause       = ($urandom_range(0, 7) == 0);
      bus.auto_reload = 1'($urandom_range(0, 1));
      if (m_st == M_IDLE) bus.prescale = 4'($urandom_range(0, 3));
      step();
    end
    rst = 1'b1;
    clear_ctl();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
